serial_relational_compare: RTL and testbench

//  Bit-serial magnitude comparator: two WIDTH-bit operands stream in MSB-first,
//  one bit pair per accepted cycle. After the last bit it presents the six flags
//  of the parallel comparator (>, <, >=, <=, ==, !=) and the reassembled words.

---
 rtl/serial_relational_compare_pkg.sv | 41 ++++
 rtl/serial_relational_compare_if.sv | 31 +++
 rtl/serial_relational_compare_cmp_cell.sv | 47 ++++
 rtl/serial_relational_compare.sv | 134 +++++++++++++
 tb/tb_serial_relational_compare.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/serial_relational_compare_pkg.sv
// Shared types for the bit-serial relational comparator: FSM state encoding,
// flag index enum and a helper that expands the gt/lt decision into six flags.
package serial_relational_compare_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_e;

    localparam int unsigned NUM_FLAGS = 6;

    typedef enum logic [2:0] {
        GT = 3'd0,
        LT = 3'd1,
        GE = 3'd2,
        LE = 3'd3,
        EQ = 3'd4,
        NE = 3'd5
    } flag_idx_e;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    // Six relational flags derived from the two decision bits
    function automatic flags_t flags_from(input logic gt, input logic lt);
        flags_t f;
        f     = '0;
        f[GT] = gt;
        f[LT] = lt;
        f[GE] = ~lt;
        f[LE] = ~gt;
        f[EQ] = ~gt & ~lt;
        f[NE] = gt | lt;
        return f;
    endfunction

endpackage

// File: rtl/serial_relational_compare_if.sv
// Serial operand/result bundle between a bit source (master) and the comparator (slave).
interface serial_relational_compare_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             bit_valid;
    logic             a_bit;
    logic             b_bit;
    logic             busy;
    logic             done;
    logic             greater;
    logic             lease;
    logic             no_lease;
    logic             no_great;
    logic             equal;
    logic             no_equal;
    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  busy, done, greater, lease, no_lease, no_great, equal, no_equal,
        input  a_word, b_word
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output busy, done, greater, lease, no_lease, no_great, equal, no_equal,
        output a_word, b_word
    );
endinterface

// File: rtl/serial_relational_compare_cmp_cell.sv
// Decision cell: first differing bit pair (MSB first) decides gt/lt, then freezes.
// Outputs _c are the next-state decision, including the bit accepted this cycle.
module serial_cmp_cell #(
    parameter bit SIGNED = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_en,
    input  logic msb,
    input  logic a_bit,
    input  logic b_bit,
    output logic gt_c,
    output logic lt_c
);

    logic gt_q, gt_d;
    logic lt_q, lt_d;
    logic a_wins;

    always_comb begin
        gt_d   = gt_q;
        lt_d   = lt_q;
        // The two's-complement sign bit carries inverted weight
        a_wins = (msb && SIGNED) ? ~a_bit : a_bit;
        if (clear) begin
            gt_d = 1'b0;
            lt_d = 1'b0;
        end else if (bit_en && !gt_q && !lt_q && (a_bit ^ b_bit)) begin
            gt_d = a_wins;
            lt_d = ~a_wins;
        end
        gt_c = gt_d;
        lt_c = lt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gt_q <= 1'b0;
            lt_q <= 1'b0;
        end else begin
            gt_q <= gt_d;
            lt_q <= lt_d;
        end
    end

endmodule

// File: rtl/serial_relational_compare.sv
// Bit-serial magnitude comparator: FSM, bit counter, shift registers and result flops.
module serial_relational_compare
    import serial_relational_compare_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_relational_compare_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   a_word_q, a_word_d;
    logic [WIDTH-1:0]   b_word_q, b_word_d;
    flags_t             flags_q, flags_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic accept_c;
    logic last_c;
    logic msb_c;
    logic gt_c;
    logic lt_c;

    // A start always wins over a same-cycle bit
    assign accept_c = (state_q == SHIFT) && bus.bit_valid && !bus.start;
    assign last_c   = accept_c && (cnt_q == CNT_W'(WIDTH - 1));
    assign msb_c    = (cnt_q == '0);

    serial_cmp_cell #(
        .SIGNED (SIGNED)
    ) u_cell (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.start),
        .bit_en (accept_c),
        .msb    (msb_c),
        .a_bit  (bus.a_bit),
        .b_bit  (bus.b_bit),
        .gt_c   (gt_c),
        .lt_c   (lt_c)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        a_word_d = a_word_q;
        b_word_d = b_word_q;
        flags_d  = flags_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (bus.start) begin
                    cnt_d = '0;
                end else if (accept_c) begin
                    a_sr_d = WIDTH'({a_sr_q, bus.a_bit});
                    b_sr_d = WIDTH'({b_sr_q, bus.b_bit});
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (last_c) begin
                        state_d  = DONE;
                        a_word_d = a_sr_d;
                        b_word_d = b_sr_d;
                        flags_d  = flags_from(gt_c, lt_c);
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = bus.start ? SHIFT : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (bus.start) begin
            flags_d = '0;
        end

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            a_word_q <= '0;
            b_word_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            a_word_q <= a_word_d;
            b_word_q <= b_word_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.greater  = flags_q[GT];
    assign bus.lease    = flags_q[LT];
    assign bus.no_lease = flags_q[GE];
    assign bus.no_great = flags_q[LE];
    assign bus.equal    = flags_q[EQ];
    assign bus.no_equal = flags_q[NE];
    assign bus.a_word   = a_word_q;
    assign bus.b_word   = b_word_q;

endmodule

// File: tb/tb_serial_relational_compare.sv
// Directed bench: unsigned and signed comparator instances fed the same serial stream.
module tb_serial_relational_compare;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests    = 0;
    int fails    = 0;
    int cyc_n    = 0;
    int done_cnt = 0;

    serial_relational_compare_if #(.WIDTH(4)) u_if ();
    serial_relational_compare_if #(.WIDTH(4)) s_if ();

    assign s_if.start     = u_if.start;
    assign s_if.bit_valid = u_if.bit_valid;
    assign s_if.a_bit     = u_if.a_bit;
    assign s_if.b_bit     = u_if.b_bit;

    serial_relational_compare #(.WIDTH(4), .SIGNED(1'b0)) u_dut (
        .clk (clk), .rst (rst), .bus (u_if.slave)
    );
    serial_relational_compare #(.WIDTH(4), .SIGNED(1'b1)) s_dut (
        .clk (clk), .rst (rst), .bus (s_if.slave)
    );

    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(negedge clk) if (u_if.done) done_cnt++;

    // Flag order: greater, lease, no_lease, no_great, equal, no_equal
    localparam logic [5:0] F_GT   = 6'b101001;
    localparam logic [5:0] F_LT   = 6'b010101;
    localparam logic [5:0] F_EQ   = 6'b001110;
    localparam logic [5:0] F_NONE = 6'b000000;

    function automatic logic [5:0] uf();
        return {u_if.greater, u_if.lease, u_if.no_lease, u_if.no_great, u_if.equal, u_if.no_equal};
    endfunction

    function automatic logic [5:0] sf();
        return {s_if.greater, s_if.lease, s_if.no_lease, s_if.no_great, s_if.equal, s_if.no_equal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic a, input logic b);
        u_if.start     = st;
        u_if.bit_valid = v;
        u_if.a_bit     = a;
        u_if.b_bit     = b;
    endtask

    // Called at a negedge: drives start now, streams 4 bits MSB first with an
    // optional gap, and returns at the negedge where done must be high.
    task automatic send(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input int gap_after, input int gap_len, input logic v0,
                        input logic [5:0] exp_u, input logic [5:0] exp_s);
        int t0;
        t0 = cyc_n;
        drive(1'b1, v0, 1'b0, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            if (i == 3 - gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    drive(1'b0, 1'b0, 1'b1, 1'b0);
                    chk({tag, "_gap_busy"}, 32'(u_if.busy), 32'd1);
                    chk({tag, "_gap_done"}, 32'(u_if.done), 32'd0);
                    @(negedge clk);
                end
            end
            drive(1'b0, 1'b1, a[i], b[i]);
            chk({tag, "_busy"}, 32'(u_if.busy), 32'd1);
            chk({tag, "_done_early"}, 32'(u_if.done), 32'd0);
            chk({tag, "_flags_cleared"}, 32'(uf()), 32'(F_NONE));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_done"}, 32'(u_if.done), 32'd1);
        chk({tag, "_latency"}, 32'(cyc_n - t0), 32'(5 + gap_len));
        chk({tag, "_uflags"}, 32'(uf()), 32'(exp_u));
        chk({tag, "_sflags"}, 32'(sf()), 32'(exp_s));
        chk({tag, "_a_word"}, 32'(u_if.a_word), 32'(a));
        chk({tag, "_b_word"}, 32'(u_if.b_word), 32'(b));
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(u_if.busy), 32'd0);
        chk("rst_done", 32'(u_if.done), 32'd0);
        chk("rst_flags", 32'(uf()), 32'(F_NONE));
        chk("rst_a_word", 32'(u_if.a_word), 32'd0);
        chk("rst_b_word", 32'(u_if.b_word), 32'd0);
        rst = 1'b0;

        // bit_valid without start is ignored in IDLE
        repeat (3) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_busy", 32'(u_if.busy), 32'd0);
        chk("idle_done", 32'(u_if.done), 32'd0);
        chk("idle_flags", 32'(uf()), 32'(F_NONE));

        // 1010 vs 0111: unsigned 10>7, signed -6<7
        @(negedge clk);
        send("t1", 4'b1010, 4'b0111, 0, 0, 1'b0, F_GT, F_LT);
        @(negedge clk);
        chk("t1_pulse_end", 32'(u_if.done), 32'd0);
        chk("t1_busy_after", 32'(u_if.busy), 32'd0);
        chk("t1_flags_hold", 32'(uf()), 32'(F_GT));
        chk("t1_a_word_hold", 32'(u_if.a_word), 32'hA);

        @(negedge clk);
        send("t2_eq", 4'b1100, 4'b1100, 0, 0, 1'b0, F_EQ, F_EQ);

        // 1000 vs 0111: unsigned 8>7, signed -8<7
        @(negedge clk);
        send("t3_sign", 4'b1000, 4'b0111, 0, 0, 1'b0, F_GT, F_LT);

        // 0011 vs 0101 with a 3-cycle gap after two bits
        @(negedge clk);
        send("t4_gap", 4'b0011, 4'b0101, 2, 3, 1'b0, F_LT, F_LT);

        // Abort after two bits (which would decide lt), restart with a discarded same-cycle bit
        @(negedge clk);
        d0 = done_cnt;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b0, 1'b1);
        end
        @(negedge clk);
        send("t5_abort", 4'b1111, 4'b0000, 0, 0, 1'b1, F_GT, F_LT);
        @(negedge clk);
        chk("t5_single_done", 32'(done_cnt - d0), 32'd1);

        // Reset after three bits, with a fourth bit offered alongside reset
        @(negedge clk);
        d0 = done_cnt;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_rst_busy", 32'(u_if.busy), 32'd0);
        chk("t5_rst_done", 32'(u_if.done), 32'd0);
        chk("t5_rst_flags", 32'(uf()), 32'(F_NONE));
        chk("t5_rst_a_word", 32'(u_if.a_word), 32'd0);
        chk("t5_rst_b_word", 32'(u_if.b_word), 32'd0);
        repeat (6) @(negedge clk);
        chk("t5_rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_rst_idle", 32'(u_if.busy), 32'd0);

        // Back-to-back: second start in the DONE cycle
        @(negedge clk);
        d0 = done_cnt;
        send("t6_first", 4'b1010, 4'b0111, 0, 0, 1'b0, F_GT, F_LT);
        send("t6_second", 4'b0001, 4'b0010, 0, 0, 1'b0, F_LT, F_LT);
        @(negedge clk);
        chk("t6_two_dones", 32'(done_cnt - d0), 32'd2);
        chk("t6_flags_hold", 32'(uf()), 32'(F_LT));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
